// File: rtl/cpu_action_scheduler.sv
// ---------------------------------------------------------------------------
// cpu_action_scheduler
//
// Turns the 5-bit LFSR stream into timed move commands for the CPU fighter.
// After a randomised cooldown (counted in video frames) it picks an action,
// biased by whether the human player is in range, and offers it to the
// fighter FSM over a valid/ack handshake. An offer that is not accepted
// within TIMEOUT frames is dropped and counted.
//
// Parameters:
//   COOLDOWN_MIN  minimum frames between offers (1..24)
//   TIMEOUT       frames an offer stays valid without ack (1..255)
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        game running; low forces IDLE
//   frame_tick    one-cycle strobe per video frame
//   random5bit    random value from the LFSR
//   near          player within attack range
//   action_ack    fighter FSM accepts the current offer
//   action        offered action code (registered)
//   action_valid  offer pending (registered)
//   busy          scheduler is not idle (registered)
//   drop_cnt      saturating count of timed-out offers (registered)
// ---------------------------------------------------------------------------
module cpu_action_scheduler #(
   parameter int COOLDOWN_MIN = 4,
   parameter int TIMEOUT      = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic [4:0] random5bit,
   input  logic       near,
   input  logic       action_ack,
   output logic [2:0] action,
   output logic       action_valid,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   localparam logic [2:0] ACT_STAND       = 3'd0;
   localparam logic [2:0] ACT_WALK_TOWARD = 3'd1;
   localparam logic [2:0] ACT_WALK_AWAY   = 3'd2;
   localparam logic [2:0] ACT_PUNCH       = 3'd3;
   localparam logic [2:0] ACT_KICK        = 3'd4;
   localparam logic [2:0] ACT_BLOCK       = 3'd5;
   localparam logic [2:0] ACT_JUMP        = 3'd6;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_PICK,
      S_OFFER
   } state_t;

   state_t     state;
   logic [4:0] wait_cnt;
   logic [7:0] timeout_cnt;
   logic [2:0] last_action;

   logic [2:0] candidate;
   logic [2:0] picked;
   logic [4:0] reload_val;

   // Cooldown length for the next wait: the fixed minimum plus a random
   // 0..7 frames taken from the upper LFSR bits. Worst case 24+7 fits 5 bits.
   always_comb begin
      reload_val = 5'(COOLDOWN_MIN) + {2'b00, random5bit[4:2]};
   end

   // Action choice from the low LFSR bits. In range the fighter mostly
   // attacks or defends; out of range it mostly closes the distance.
   always_comb begin
      candidate = ACT_STAND;
      if (near) begin
         case (random5bit[1:0])
            2'd0:    candidate = ACT_PUNCH;
            2'd1:    candidate = ACT_KICK;
            2'd2:    candidate = ACT_BLOCK;
            default: candidate = ACT_WALK_AWAY;
         endcase
      end else begin
         case (random5bit[1:0])
            2'd0,
            2'd1:    candidate = ACT_WALK_TOWARD;
            2'd2:    candidate = ACT_STAND;
            default: candidate = ACT_JUMP;
         endcase
      end
   end

   // Avoid spamming the same strike twice in a row: a repeated PUNCH or
   // KICK (relative to the last accepted action) becomes a BLOCK instead.
   always_comb begin
      picked = candidate;
      if ((candidate == ACT_PUNCH || candidate == ACT_KICK) &&
          candidate == last_action) begin
         picked = ACT_BLOCK;
      end
   end

   // Main scheduler FSM. Every output is a flop updated here so nothing
   // combinational reaches the ports. Dropping enable overrides whatever
   // the FSM was doing, but the drop statistics survive it. In OFFER an
   // ack takes priority over a coincident final timeout tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         action       <= ACT_STAND;
         action_valid <= 1'b0;
         busy         <= 1'b0;
         drop_cnt     <= 8'd0;
         last_action  <= ACT_STAND;
         wait_cnt     <= 5'd0;
         timeout_cnt  <= 8'd0;
      end else if (!enable) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         action_valid <= 1'b0;
         action       <= ACT_STAND;
         last_action  <= ACT_STAND;
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_WAIT;
               busy     <= 1'b1;
               wait_cnt <= reload_val;
            end
            S_WAIT: begin
               if (frame_tick) begin
                  wait_cnt <= wait_cnt - 5'd1;
                  if (wait_cnt == 5'd1) begin
                     state <= S_PICK;
                  end
               end
            end
            S_PICK: begin
               action       <= picked;
               action_valid <= 1'b1;
               timeout_cnt  <= 8'd0;
               state        <= S_OFFER;
            end
            S_OFFER: begin
               if (action_ack) begin
                  last_action  <= action;
                  action_valid <= 1'b0;
                  wait_cnt     <= reload_val;
                  state        <= S_WAIT;
               end else if (frame_tick) begin
                  if (timeout_cnt == TIMEOUT_LAST) begin
                     action_valid <= 1'b0;
                     if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                     end
                     wait_cnt <= reload_val;
                     state    <= S_WAIT;
                  end else begin
                     timeout_cnt <= timeout_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_action_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cpu_action_scheduler
//
// Directed bench for cpu_action_scheduler. Expected action codes are pushed
// into a queue when the inputs that decide them are driven, and popped when
// the DUT raises action_valid. Inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_action_scheduler;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       frame_tick;
   logic [4:0] random5bit;
   logic       near;
   logic       action_ack;
   logic [2:0] action;
   logic       action_valid;
   logic       busy;
   logic [7:0] drop_cnt;

   int         compared;
   int         mismatched;
   logic [2:0] expQ[$];
   logic [2:0] expLast;
   logic [7:0] expDrop;
   int         ticks;
   bit         ok;

   cpu_action_scheduler #(
      .COOLDOWN_MIN (4),
      .TIMEOUT      (30)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .frame_tick   (frame_tick),
      .random5bit   (random5bit),
      .near         (near),
      .action_ack   (action_ack),
      .action       (action),
      .action_valid (action_valid),
      .busy         (busy),
      .drop_cnt     (drop_cnt)
   );

   // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decode of the action table, including repeat suppression.
   function automatic logic [2:0] expAction(input logic nr, input logic [4:0] r,
                                            input logic [2:0] last);
      logic [2:0] c;
      if (nr) begin
         case (r[1:0])
            2'd0:    c = 3'd3;
            2'd1:    c = 3'd4;
            2'd2:    c = 3'd5;
            default: c = 3'd2;
         endcase
      end else begin
         case (r[1:0])
            2'd0, 2'd1: c = 3'd1;
            2'd2:       c = 3'd0;
            default:    c = 3'd6;
         endcase
      end
      if ((c == 3'd3 || c == 3'd4) && c == last) c = 3'd5;
      return c;
   endfunction

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive the level inputs on a falling edge.
   task automatic applyStimulus(input logic en, input logic nr,
                                input logic [4:0] r, input logic ack);
      @(negedge clk);
      enable     = en;
      near       = nr;
      random5bit = r;
      action_ack = ack;
   endtask

   // One frame strobe lasting exactly one rising edge.
   task automatic tickFrame();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   // Tick frames until an offer appears; reports how many ticks it took.
   task automatic waitOffer(output int n, output bit found);
      found = 1'b0;
      n     = 0;
      for (int i = 1; i <= 40; i++) begin
         tickFrame();
         @(negedge clk);
         if (action_valid) begin
            n     = i;
            found = 1'b1;
            break;
         end
      end
      checkOutput("offer_arrives", {7'd0, found}, 8'd1);
   endtask

   // Compare the offered action against the oldest scoreboard entry.
   task automatic popAndCheck(input string tag);
      logic [2:0] e;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 8'd1, {7'd0, action_valid});
      end else begin
         e = expQ.pop_front();
         checkOutput(tag, {5'd0, action}, {5'd0, e});
      end
   endtask

   // Accept the pending offer for one cycle and confirm it is withdrawn.
   task automatic ackOffer(input string tag);
      @(negedge clk);
      action_ack = 1'b1;
      @(negedge clk);
      action_ack = 1'b0;
      checkOutput({tag, "_valid"}, {7'd0, action_valid}, 8'd0);
      checkOutput({tag, "_busy"}, {7'd0, busy}, 8'd1);
      expLast = action;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      expLast    = 3'd0;
      expDrop    = 8'd0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      frame_tick = 1'b0;
      random5bit = 5'd0;
      near       = 1'b0;
      action_ack = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_action", {5'd0, action}, 8'd0);
      checkOutput("rst_valid", {7'd0, action_valid}, 8'd0);
      checkOutput("rst_busy", {7'd0, busy}, 8'd0);
      checkOutput("rst_drop", drop_cnt, 8'd0);
      rst_n = 1'b1;

      // Basic offer: load 4+1=5, WALK_TOWARD two edges after the 5th tick
      applyStimulus(1'b1, 1'b0, 5'b00101, 1'b0);
      @(negedge clk);
      checkOutput("basic_busy", {7'd0, busy}, 8'd1);
      expQ.push_back(expAction(1'b0, 5'b00101, expLast));
      repeat (4) tickFrame();
      checkOutput("basic_early_valid", {7'd0, action_valid}, 8'd0);
      tickFrame();
      checkOutput("basic_pick_valid", {7'd0, action_valid}, 8'd0);
      @(negedge clk);
      checkOutput("basic_valid", {7'd0, action_valid}, 8'd1);
      popAndCheck("basic_action");
      ackOffer("basic_ack");
      checkOutput("basic_hold_action", {5'd0, action}, 8'd1);

      // Restart cleanly for repeat suppression
      applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
      @(negedge clk);
      checkOutput("idle_action", {5'd0, action}, 8'd0);
      expLast = 3'd0;
      applyStimulus(1'b1, 1'b1, 5'b00000, 1'b0);

      // Repeat suppression: PUNCH, then BLOCK, then PUNCH again
      expQ.push_back(expAction(1'b1, 5'b00000, expLast));
      waitOffer(ticks, ok);
      checkOutput("rep1_ticks", 8'(ticks), 8'd4);
      popAndCheck("rep1_action");
      ackOffer("rep1_ack");
      expQ.push_back(expAction(1'b1, 5'b00000, expLast));
      waitOffer(ticks, ok);
      checkOutput("rep2_ticks", 8'(ticks), 8'd4);
      popAndCheck("rep2_action");
      ackOffer("rep2_ack");
      expQ.push_back(expAction(1'b1, 5'b00000, expLast));
      waitOffer(ticks, ok);
      popAndCheck("rep3_action");
      ackOffer("rep3_ack");

      // Timeout: last is PUNCH so this offer is BLOCK; never acked
      expQ.push_back(expAction(1'b1, 5'b00000, expLast));
      waitOffer(ticks, ok);
      popAndCheck("to_action");
      repeat (29) tickFrame();
      checkOutput("to_valid_29", {7'd0, action_valid}, 8'd1);
      tickFrame();
      expDrop = 8'd1;
      checkOutput("to_valid_30", {7'd0, action_valid}, 8'd0);
      checkOutput("to_drop", drop_cnt, expDrop);
      checkOutput("to_busy", {7'd0, busy}, 8'd1);

      // Dropped offer left last_action at PUNCH, so BLOCK again
      expQ.push_back(expAction(1'b1, 5'b00000, expLast));
      waitOffer(ticks, ok);
      popAndCheck("to_last_kept");

      // Ack coincident with the 30th timeout tick: ack wins
      repeat (29) tickFrame();
      @(negedge clk);
      frame_tick = 1'b1;
      action_ack = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      action_ack = 1'b0;
      expLast    = 3'd5;
      checkOutput("race_valid", {7'd0, action_valid}, 8'd0);
      checkOutput("race_drop", drop_cnt, expDrop);
      expQ.push_back(expAction(1'b1, 5'b00000, expLast));
      waitOffer(ticks, ok);
      popAndCheck("race_last_updated");

      // 300 forced drops saturate the counter
      for (int i = 0; i < 300; i++) begin
         repeat (30) tickFrame();
         if (expDrop != 8'hFF) expDrop = expDrop + 8'd1;
         waitOffer(ticks, ok);
         if (!ok) break;
      end
      checkOutput("sat_drop", drop_cnt, expDrop);
      checkOutput("sat_action", {5'd0, action}, 8'd3);

      // Enable dropped during OFFER
      applyStimulus(1'b0, 1'b0, 5'b00111, 1'b0);
      @(negedge clk);
      checkOutput("dis_valid", {7'd0, action_valid}, 8'd0);
      checkOutput("dis_action", {5'd0, action}, 8'd0);
      checkOutput("dis_busy", {7'd0, busy}, 8'd0);
      checkOutput("dis_drop_kept", drop_cnt, expDrop);
      expLast = 3'd0;
      applyStimulus(1'b1, 1'b0, 5'b00111, 1'b0);
      @(negedge clk);
      checkOutput("reen_busy", {7'd0, busy}, 8'd1);
      checkOutput("reen_valid", {7'd0, action_valid}, 8'd0);
      expQ.push_back(expAction(1'b0, 5'b00111, expLast));
      waitOffer(ticks, ok);
      checkOutput("reen_ticks", 8'(ticks), 8'd5);
      popAndCheck("reen_action");
      ackOffer("reen_ack");

      // Asynchronous reset mid-WAIT, between clock edges
      repeat (2) tickFrame();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_action", {5'd0, action}, 8'd0);
      checkOutput("arst_valid", {7'd0, action_valid}, 8'd0);
      checkOutput("arst_busy", {7'd0, busy}, 8'd0);
      checkOutput("arst_drop", drop_cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      checkOutput("sb_drained", 8'(expQ.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cpu_action_scheduler.md
# cpu_action_scheduler

Consumes the 5-bit pseudo-random stream from the game's LFSR generator and turns it into timed move commands for the CPU-controlled fighter. Each command is offered to the fighter FSM over a valid/ack handshake. The block waits a randomised number of frames, picks an action biased by whether the human player is in range, and drops the offer if it is not accepted in time. It sits between the random source and the CPU fighter's movement/attack FSM, clocked by the system clock and paced by the frame strobe.

## Interface
- COOLDOWN_MIN, 4: minimum frames between offers; legal range 1..24.
- TIMEOUT, 30: frames an offer stays valid without ack before it is dropped; legal range 1..255.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  game running; low forces IDLE.
- frame_tick  in  1  one-cycle strobe per video frame.
- random5bit  in  5  random value from the LFSR (r[4:0]).
- near  in  1  player within attack range.
- action  out  3  action code: 0 STAND, 1 WALK_TOWARD, 2 WALK_AWAY, 3 PUNCH, 4 KICK, 5 BLOCK, 6 JUMP.
- action_valid  out  1  offer pending.
- action_ack  in  1  fighter FSM accepts the current offer.
- busy  out  1  state != IDLE.
- drop_cnt  out  8  saturating count of timed-out offers.

## Operation
- States: IDLE, WAIT, PICK, OFFER.
- **IDLE**
  - Outputs are 0.
  - When enable=1 is sampled, go to WAIT and load wait_cnt = COOLDOWN_MIN + r[4:2] (5-bit counter).
- **WAIT**
  - Each frame_tick decrements wait_cnt.
  - A tick that arrives while wait_cnt==1 moves the state to PICK.
  - Non-tick cycles hold wait_cnt.
- **PICK** (exactly one cycle). Samples random5bit and decodes the candidate:
  - near=1, r[1:0]: 0 → PUNCH, 1 → KICK, 2 → BLOCK, 3 → WALK_AWAY.
  - near=0, r[1:0]: 0 or 1 → WALK_TOWARD, 2 → STAND, 3 → JUMP.
  - Repeat suppression: if the candidate is PUNCH or KICK and equals last_action, substitute BLOCK.
  - Registers the result into action, sets action_valid=1, clears timeout_cnt, and goes to OFFER.
- **OFFER**
  - action and action_valid are held stable.
  - On action_ack=1: record last_action=action, drop action_valid, reload wait_cnt from the current random5bit, and go to WAIT.
  - Otherwise each frame_tick increments timeout_cnt.
  - A tick that arrives while timeout_cnt==TIMEOUT-1, with no ack, is a drop:
    - action_valid goes to 0.
    - drop_cnt increments, saturating at 255.
    - last_action is unchanged.
    - wait_cnt reloads and the state goes to WAIT.
  - ack and the final timeout tick in the same cycle: ack wins, no drop.
- action_ack outside OFFER is ignored.
- enable=0 sampled in any state:
  - Next state is IDLE; action_valid=0, action=0, last_action=0.
  - drop_cnt is retained.
- action holds its last offered value in WAIT; it returns to 0 only via reset or IDLE.

## Timing
- Reset values (async on rst_n=0): state IDLE; action 0; action_valid 0; busy 0; drop_cnt 0; last_action 0; wait_cnt 0; timeout_cnt 0.
- All outputs are registered; no combinational path from any input to any output.
- enable sampled high at edge e: busy=1 after e.
- The L-th frame_tick (L = loaded wait_cnt) is sampled at edge t:
  - PICK after t.
  - action_valid=1 with the new action after t+1.
- ack sampled at edge a: action_valid=0 after a, and the state is WAIT.
- Timeout: valid falls after the edge sampling the TIMEOUT-th frame_tick counted in OFFER.
- Minimum offer spacing is COOLDOWN_MIN frames plus 2 cycles.

## Test plan
- **Basic offer.** COOLDOWN_MIN=4, near=0, random5bit=5'b00101 held, enable=1, ack tied 0 → load 5; action=1 (WALK_TOWARD) and action_valid=1 two cycles after the 5th tick.
- **Repeat suppression.** near=1, random5bit=5'b00000, ack the first offer one cycle after valid → first action=3 (PUNCH); the next offer after 4 ticks is 5 (BLOCK); ack that, and the third offer is 3 again.
- **Timeout.** TIMEOUT=30, never ack → valid falls after the 30th tick in OFFER, drop_cnt=1; after 300 forced drops drop_cnt=255.
- **Ack on the final timeout tick.** action_ack=1 in the same cycle as the 30th timeout tick → no drop, drop_cnt unchanged, last_action updated.
- **Enable drop during OFFER.** enable=0 → next cycle action_valid=0, action=0, busy=0; re-enable restarts from WAIT.
- **Asynchronous reset.** rst_n pulsed low mid-WAIT (between clock edges) → all outputs 0 immediately, no clock edge needed.
